// File: rtl/universal_shift_register_if.sv
// Data-side bundle for the universal shift register: mode/serial/parallel inputs and
// the register taps. The master drives the controls; the slave is the register itself.
interface universal_shift_register_if #(
   parameter int unsigned WIDTH = 4
);
   logic             right_s_in;
   logic             left_s_in;
   logic [1:0]       select;
   logic [WIDTH-1:0] pin;
   logic [WIDTH-1:0] pout;
   logic             s_left;
   logic             s_right;

   modport master (
      output right_s_in,
      output left_s_in,
      output select,
      output pin,
      input  pout,
      input  s_left,
      input  s_right
   );

   modport slave (
      input  right_s_in,
      input  left_s_in,
      input  select,
      input  pin,
      output pout,
      output s_left,
      output s_right
   );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load each clock.
// Synchronous active-low reset wins over every mode.
module universal_shift_register #(
   parameter int unsigned WIDTH = 4
) (
   input logic                        clk,
   input logic                        reset,
   universal_shift_register_if.slave  bus
);

   typedef enum logic [1:0] {
      ModeHold  = 2'b00,
      ModeRight = 2'b01,
      ModeLeft  = 2'b10,
      ModeLoad  = 2'b11
   } mode_e;

   mode_e            mode;
   logic [WIDTH-1:0] pout_q;
   logic [WIDTH-1:0] pout_d;

   assign mode = mode_e'(bus.select);

   always_comb begin
      pout_d = pout_q;
      unique case (mode)
         ModeHold:  pout_d = pout_q;
         ModeRight: pout_d = {bus.right_s_in, pout_q[WIDTH-1:1]};
         ModeLeft:  pout_d = {pout_q[WIDTH-2:0], bus.left_s_in};
         ModeLoad:  pout_d = bus.pin;
         default:   pout_d = pout_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pout_q <= '0;
      end else begin
         pout_q <= pout_d;
      end
   end

   // Serial taps come straight off the register: they show the bit about to leave.
   assign bus.pout    = pout_q;
   assign bus.s_left  = pout_q[WIDTH-1];
   assign bus.s_right = pout_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: stimulus pushes the expected register value per edge, a monitor
// pops and compares it just after each rising edge.
module tb_universal_shift_register;
   localparam int unsigned W    = 4;
   localparam int unsigned MASK = (1 << W) - 1;

   typedef struct {
      int unsigned value;
      string       name;
   } exp_t;

   logic clk;
   logic reset;
   exp_t sb[$];
   int   checks;
   int   errors;
   int unsigned model;

   universal_shift_register_if #(.WIDTH(W)) bus ();

   universal_shift_register #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic compare(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   // Monitor: the register presents a new value after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            compare({e.name, ".pout"}, 32'(bus.pout), e.value);
            compare({e.name, ".s_left"}, 32'(bus.s_left), (e.value >> (W - 1)) & 1);
            compare({e.name, ".s_right"}, 32'(bus.s_right), e.value & 1);
         end
      end
   end

   // Reference: register value as an integer, updated with shifts and masks.
   task automatic step(input bit rst_n, input bit [1:0] sel, input bit rsin, input bit lsin,
                       input int unsigned pinv, input string name);
      exp_t e;
      @(negedge clk);
      reset          = rst_n;
      bus.select     = sel;
      bus.right_s_in = rsin;
      bus.left_s_in  = lsin;
      bus.pin        = W'(pinv);
      if (!rst_n) begin
         model = 0;
      end else begin
         case (sel)
            2'd1:    model = (model >> 1) | (int'(rsin) << (W - 1));
            2'd2:    model = ((model << 1) | int'(lsin)) & MASK;
            2'd3:    model = pinv & MASK;
            default: model = model;
         endcase
      end
      e.value = model;
      e.name  = name;
      sb.push_back(e);
   endtask

   initial begin
      int unsigned exp_right[4];
      int unsigned exp_left[4];
      int budget;
      checks = 0;
      errors = 0;
      model  = 0;
      reset          = 1'b1;
      bus.select     = 2'b00;
      bus.right_s_in = 1'b0;
      bus.left_s_in  = 1'b0;
      bus.pin        = '0;

      step(1'b0, 2'b11, 1, 1, 4'b1111, "reset");
      step(1'b1, 2'b11, 0, 0, 4'b1010, "load");
      step(1'b1, 2'b11, 1, 1, 4'b1010, "load_hold1");
      step(1'b1, 2'b11, 0, 1, 4'b1010, "load_hold2");
      if (model != 4'b1010) $display("bench model out of step after load");

      exp_right = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 2'b01, 0, 1, 4'b1111, $sformatf("shr%0d", i));
         if (model != exp_right[i]) $display("bench model disagrees at shr%0d", i);
      end

      step(1'b1, 2'b11, 0, 0, 4'b1010, "reload");
      exp_left = '{4'b0101, 4'b1011, 4'b0111, 4'b1111};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 2'b10, i[0], 1, 4'b0000, $sformatf("shl%0d", i));
         if (model != exp_left[i]) $display("bench model disagrees at shl%0d", i);
      end

      step(1'b1, 2'b11, 0, 0, 4'b1101, "load1101");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b00, i[0], ~i[0], $urandom_range(0, 15), $sformatf("hold%0d", i));
      end

      step(1'b1, 2'b10, 0, 1, 4'b0000, "midshl");
      step(1'b0, 2'b10, 1, 1, 4'b1111, "reset_midshift");
      step(1'b1, 2'b11, 0, 0, 4'b1101, "load_after_reset");

      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 15) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 15), $sformatf("rand%0d", i));
      end

      budget = 10;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
